// File: rtl/sr_flop_checker.sv
// ============================================================================
// Module   : sr_flop_checker
// Brief    : Drives a fixed set/reset vector sequence into an SR flop and
//            checks its q/qb outputs against an internal SR reference model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sr_flop_checker #(
    parameter int SETTLE = 1,
    parameter int ERR_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_rst,
    output logic             s_out,
    output logic             r_out,
    input  logic             q_in,
    input  logic             qb_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       vec_idx
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_DRIVE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Bit i of each mask is the s (or r) value of vector i.
    localparam logic [7:0] c_vec_s       = 8'b0111_0010;
    localparam logic [7:0] c_vec_r       = 8'b0010_1000;
    localparam logic [3:0] c_settle_last = 4'(SETTLE - 1);

    state_t           r_state;
    logic [3:0]       r_wait_cnt;
    logic             r_m;

    logic [2:0]       w_idx_inc;
    logic             w_s;
    logic             w_r;
    logic             w_m_next;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;

    assign w_idx_inc = vec_idx + 3'd1;
    assign w_s       = c_vec_s[vec_idx];
    assign w_r       = c_vec_r[vec_idx];

    // Forbidden 11 leaves the model alone and suppresses the compare.
    always_comb begin
        w_m_next   = r_m;
        w_mismatch = 1'b0;
        if (w_s && !w_r) begin
            w_m_next = 1'b1;
        end else if (!w_s && w_r) begin
            w_m_next = 1'b0;
        end
        if (!(w_s && w_r)) begin
            w_mismatch = (q_in != w_m_next) || (qb_in != !w_m_next);
        end
        w_err_next = err_count;
        if (w_mismatch && (err_count != {ERR_W{1'b1}})) begin
            w_err_next = err_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_m        <= 1'b0;
            dut_rst    <= 1'b0;
            s_out      <= 1'b0;
            r_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            vec_idx    <= 3'd0;
        end else begin
            done    <= 1'b0;
            dut_rst <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    s_out <= 1'b0;
                    r_out <= 1'b0;
                    if (start) begin
                        r_state   <= ST_INIT;
                        dut_rst   <= 1'b1;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        err_count <= '0;
                        vec_idx   <= 3'd0;
                        r_m       <= 1'b0;
                    end
                end
                ST_INIT: begin
                    r_state <= ST_DRIVE;
                    s_out   <= w_s;
                    r_out   <= w_r;
                end
                ST_DRIVE: begin
                    r_state    <= ST_WAIT;
                    r_wait_cnt <= 4'd0;
                end
                ST_WAIT: begin
                    if (r_wait_cnt == c_settle_last) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                ST_CHECK: begin
                    r_m       <= w_m_next;
                    err_count <= w_err_next;
                    if (vec_idx == 3'd7) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        pass    <= (w_err_next == '0);
                        s_out   <= 1'b0;
                        r_out   <= 1'b0;
                    end else begin
                        r_state <= ST_DRIVE;
                        vec_idx <= w_idx_inc;
                        s_out   <= c_vec_s[w_idx_inc];
                        r_out   <= c_vec_r[w_idx_inc];
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
